seg_scan_ctrl: RTL and testbench

Time-multiplexing scan controller for the 4-digit common-anode seven-segment display. It steps a 2-bit digit index through digits 0..3 and decodes the selected hex nibble to segments. It drives the active-low anode one-hot, with a blanking gap between digits to prevent ghosting. It sits between the display-value producer and the board pins, and owns all display refresh timing.

---
 rtl/seg_scan_ctrl.sv | 172 +++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan controller: blank gap, then lit phase per digit,
// with a per-frame input snapshot and optional leading-zero suppression.
module seg_scan_ctrl #(
    parameter int BLANK_CYC = 16,
    parameter int ON_CYC    = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_in,
    input  logic        lz_en,
    output logic [1:0]  digit_sel,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    localparam int MAXC = (BLANK_CYC > ON_CYC) ? BLANK_CYC : ON_CYC;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        ON    = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    sel_q, sel_d;
    logic [15:0]   snapDig_q, snapDig_d;
    logic [3:0]    snapDp_q, snapDp_d;
    logic          snapLz_q, snapLz_d;
    logic          tick_q, tick_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [3:0]    supp;
    logic [3:0]    nib;

    function automatic logic [6:0] hexDecode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sel_q     <= 2'd0;
            snapDig_q <= 16'h0;
            snapDp_q  <= 4'h0;
            snapLz_q  <= 1'b0;
            tick_q    <= 1'b0;
            an_q      <= 4'hF;
            seg_q     <= 7'h7F;
            dp_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            snapDig_q <= snapDig_d;
            snapDp_q  <= snapDp_d;
            snapLz_q  <= snapLz_d;
            tick_q    <= tick_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
        end
    end

    // Outputs are decoded from next-state values so the registered pins line up
    // exactly with the registered state they describe.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        snapDig_d = snapDig_q;
        snapDp_d  = snapDp_q;
        snapLz_d  = snapLz_q;
        tick_d    = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            sel_d   = 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d   = BLANK;
                    cnt_d     = '0;
                    sel_d     = 2'd0;
                    snapDig_d = digits;
                    snapDp_d  = dp_in;
                    snapLz_d  = lz_en;
                end
                BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ON;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ON: begin
                    if (cnt_q == ON_LAST) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                        sel_d   = sel_q + 2'd1;
                        if (sel_q == 2'd3) begin
                            tick_d    = 1'b1;
                            snapDig_d = digits;
                            snapDp_d  = dp_in;
                            snapLz_d  = lz_en;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    sel_d   = 2'd0;
                end
            endcase
        end
    end

    // A digit is suppressed when it and every higher nibble are zero; digit 0 always shows.
    always_comb begin
        supp[3] = snapLz_d && (snapDig_d[15:12] == 4'h0);
        supp[2] = supp[3] && (snapDig_d[11:8] == 4'h0);
        supp[1] = supp[2] && (snapDig_d[7:4] == 4'h0);
        supp[0] = 1'b0;
        nib     = snapDig_d[{sel_d, 2'b00} +: 4];
        an_d    = 4'hF;
        seg_d   = 7'h7F;
        dp_d    = 1'b1;
        if (state_d == ON && !supp[sel_d]) begin
            an_d  = ~(4'b0001 << sel_d);
            seg_d = hexDecode(nib);
            dp_d  = ~snapDp_d[sel_d];
        end
    end

    assign digit_sel  = sel_q;
    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a frame-position model predicts every cycle's
// pins, a monitor on the falling edge pops and compares.
module tb_seg_scan_ctrl;

    localparam int B     = 2;
    localparam int O     = 4;
    localparam int SLOT  = B + O;
    localparam int FRAME = 4 * SLOT;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic        lz_en;
    logic [1:0]  digit_sel;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    seg_scan_ctrl #(.BLANK_CYC(B), .ON_CYC(O)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .digits(digits),
        .dp_in(dp_in), .lz_en(lz_en), .digit_sel(digit_sel), .an(an),
        .seg(seg), .dp(dp), .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [1:0] sel;
        logic       tick;
    } exp_t;

    exp_t expQ[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    logic [6:0] hexSeg [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    bit          mIdle = 1'b1;
    int          t     = 0;
    logic [15:0] sDig  = 16'h0;
    logic [3:0]  sDp   = 4'h0;
    logic        sLz   = 1'b0;
    logic        mTick = 1'b0;

    function automatic exp_t modelOut();
        exp_t e;
        int   d;
        int   p;
        e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, sel: 2'd0, tick: mTick};
        if (!mIdle) begin
            d     = t / SLOT;
            p     = t % SLOT;
            e.sel = 2'(d);
            if (p >= B && !(sLz && d != 0 && (sDig >> (4 * d)) == 0)) begin
                e.an  = ~(4'(1) << d);
                e.seg = hexSeg[(sDig >> (4 * d)) & 16'hF];
                e.dp  = ~sDp[d];
            end
        end
        return e;
    endfunction

    // Reference model: position within the frame advances one per cycle.
    initial begin
        forever begin
            @(posedge clk);
            mTick = 1'b0;
            if (!rst_n) begin
                mIdle = 1'b1; t = 0; sDig = 16'h0; sDp = 4'h0; sLz = 1'b0;
            end else if (!enable) begin
                mIdle = 1'b1; t = 0;
            end else if (mIdle) begin
                mIdle = 1'b0; t = 0; sDig = digits; sDp = dp_in; sLz = lz_en;
            end else begin
                t = t + 1;
                if (t == FRAME) begin
                    t = 0; sDig = digits; sDp = dp_in; sLz = lz_en; mTick = 1'b1;
                end
            end
            expQ.push_back(modelOut());
        end
    end

    task automatic checkOutput(input exp_t e);
        exp_t got;
        got   = '{an: an, seg: seg, dp: dp, sel: digit_sel, tick: frame_tick};
        tests = tests + 1;
        if (got !== e) begin
            fails = fails + 1;
            $display("[TB] FAIL pins cycle %0d: got an=%b seg=%b dp=%b sel=%0d tick=%b, expected an=%b seg=%b dp=%b sel=%0d tick=%b",
                     cyc, got.an, got.seg, got.dp, got.sel, got.tick,
                     e.an, e.seg, e.dp, e.sel, e.tick);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cyc = cyc + 1;
            if (expQ.size() == 0) begin
                tests = tests + 1;
                fails = fails + 1;
                $display("[TB] FAIL scoreboard cycle %0d: got empty queue, expected an entry", cyc);
            end else begin
                checkOutput(expQ.pop_front());
            end
        end
    end

    task automatic applyStimulus(input logic [15:0] dg, input logic [3:0] dpv,
                                 input logic lz, input logic en);
        @(posedge clk);
        #1;
        digits = dg;
        dp_in  = dpv;
        lz_en  = lz;
        enable = en;
    endtask

    task automatic runCycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b1;
        digits = 16'h1234;
        dp_in  = 4'h0;
        lz_en  = 1'b0;
        runCycles(3);
        #1 rst_n = 1'b1;
        runCycles(2 * FRAME + 3);

        applyStimulus(16'h0050, 4'h0, 1'b1, 1'b1);
        runCycles(2 * FRAME);
        applyStimulus(16'h0000, 4'hF, 1'b1, 1'b1);
        runCycles(2 * FRAME);
        applyStimulus(16'hABCD, 4'b0100, 1'b0, 1'b1);
        runCycles(2 * FRAME);

        applyStimulus(16'h1234, 4'h0, 1'b0, 1'b1);
        runCycles(FRAME + 9);
        applyStimulus(16'h5678, 4'h0, 1'b0, 1'b1);
        runCycles(2 * FRAME);

        runCycles(15);
        applyStimulus(16'h5678, 4'h0, 1'b0, 1'b0);
        runCycles(3);
        applyStimulus(16'h5678, 4'h0, 1'b0, 1'b1);
        runCycles(FRAME);

        // Async reset mid-lit-phase: pins must go dark before any clock edge.
        applyStimulus(16'h1234, 4'h0, 1'b0, 1'b0);
        applyStimulus(16'h1234, 4'h0, 1'b0, 1'b1);
        runCycles(4);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests = tests + 1;
        if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || frame_tick !== 1'b0 || digit_sel !== 2'd0) begin
            fails = fails + 1;
            $display("[TB] FAIL async_reset: got an=%b seg=%b dp=%b tick=%b sel=%0d, expected an=1111 seg=1111111 dp=1 tick=0 sel=0",
                     an, seg, dp, frame_tick, digit_sel);
        end
        runCycles(3);
        #1 rst_n = 1'b1;
        runCycles(FRAME);

        for (int i = 0; i < 80; i++) begin
            applyStimulus(16'($urandom) >> $urandom_range(0, 16), 4'($urandom),
                          1'($urandom), ($urandom_range(0, 9) != 0));
            runCycles($urandom_range(1, 40));
        end

        runCycles(2);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
